// File: rtl/iob_shift_round_seq_if.sv
// Request/response bundle of the shift-round sequencer.
//   slave  : seen by the sequencer (takes start/man/shift, drives ready/done/results)
//   master : seen by the requester (mirror of slave)
interface iob_shift_round_seq_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SHIFT_W = 16
);
    logic               start_i;
    logic               ready_o;
    logic [DATA_W-1:0]  man_i;
    logic [SHIFT_W-1:0] shift_i;
    logic               done_o;
    logic [DATA_W-1:0]  man_o;
    logic               guard_o;
    logic               round_o;
    logic               sticky_o;
    logic               inexact_o;

    modport slave (
        input  start_i, man_i, shift_i,
        output ready_o, done_o, man_o, guard_o, round_o, sticky_o, inexact_o
    );

    modport master (
        output start_i, man_i, shift_i,
        input  ready_o, done_o, man_o, guard_o, round_o, sticky_o, inexact_o
    );
endinterface

// File: rtl/iob_shift_round_seq.sv
// Multi-cycle right shifter with guard/round/sticky capture and RNE rounding.
// Shifts at most STEP bits per cycle; a low-area stand-in for a barrel
// shifter plus sticky tree on the FP alignment path.
//   clk_i     : clock
//   arst_n_i  : asynchronous active-low reset
//   bus       : slave side of iob_shift_round_seq_if (start/ready handshake,
//               mantissa and shift in, rounded mantissa and G/R/S flags out)
module iob_shift_round_seq #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SHIFT_W = 16,
    parameter int unsigned STEP    = 4
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    iob_shift_round_seq_if.slave  bus
);
    localparam int unsigned EXT_W = DATA_W + 2;
    localparam int unsigned REM_W = $clog2(EXT_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ROUND = 2'd2
    } state_t;

    state_t              state_q, state_n;
    logic [EXT_W-1:0]    ext_q, ext_n;
    logic                s_q, s_n;
    logic [REM_W-1:0]    rem_q, rem_n;
    logic                ready_q, ready_n;
    logic                done_q, done_n;
    logic [DATA_W-1:0]   man_q, man_n;
    logic                g_q, g_n;
    logic                r_q, r_n;
    logic                st_q, st_n;
    logic                inx_q, inx_n;

    logic [REM_W-1:0]    rem_clamp;
    logic [REM_W-1:0]    amt;
    logic [REM_W-1:0]    rem_dec;
    logic                shifted_out;
    logic                up;

    // Shift amount saturated at the extended width: beyond that everything is sticky.
    always_comb begin
        if (32'(bus.shift_i) >= EXT_W) rem_clamp = REM_W'(EXT_W);
        else                           rem_clamp = REM_W'(bus.shift_i);
    end

    // Per-cycle step and OR of the bits leaving the bottom of ext.
    always_comb begin
        if (rem_q > REM_W'(STEP)) amt = REM_W'(STEP);
        else                      amt = rem_q;
        rem_dec     = rem_q - amt;
        shifted_out = 1'b0;
        for (int unsigned i = 0; i < EXT_W; i++) begin
            if (i < 32'(amt)) shifted_out = shifted_out | ext_q[i];
        end
    end

    // Round half to even: bump only past the halfway point or on an odd tie.
    assign up = ext_q[1] & (ext_q[0] | s_q | ext_q[2]);

    // Next-state and next-output logic.
    always_comb begin
        state_n = state_q;
        ext_n   = ext_q;
        s_n     = s_q;
        rem_n   = rem_q;
        ready_n = ready_q;
        done_n  = 1'b0;
        man_n   = man_q;
        g_n     = g_q;
        r_n     = r_q;
        st_n    = st_q;
        inx_n   = inx_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    ext_n   = {bus.man_i, 2'b00};
                    s_n     = 1'b0;
                    rem_n   = rem_clamp;
                    ready_n = 1'b0;
                    state_n = (rem_clamp != '0) ? SHIFT : ROUND;
                end
            end
            SHIFT: begin
                s_n   = s_q | shifted_out;
                ext_n = ext_q >> amt;
                rem_n = rem_dec;
                if (rem_dec == '0) state_n = ROUND;
            end
            ROUND: begin
                man_n   = ext_q[EXT_W-1:2] + DATA_W'(up);
                g_n     = ext_q[1];
                r_n     = ext_q[0];
                st_n    = s_q;
                inx_n   = ext_q[1] | ext_q[0] | s_q;
                done_n  = 1'b1;
                ready_n = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                ready_n = 1'b1;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= IDLE;
            ext_q   <= '0;
            s_q     <= 1'b0;
            rem_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            man_q   <= '0;
            g_q     <= 1'b0;
            r_q     <= 1'b0;
            st_q    <= 1'b0;
            inx_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            ext_q   <= ext_n;
            s_q     <= s_n;
            rem_q   <= rem_n;
            ready_q <= ready_n;
            done_q  <= done_n;
            man_q   <= man_n;
            g_q     <= g_n;
            r_q     <= r_n;
            st_q    <= st_n;
            inx_q   <= inx_n;
        end
    end

    assign bus.ready_o   = ready_q;
    assign bus.done_o    = done_q;
    assign bus.man_o     = man_q;
    assign bus.guard_o   = g_q;
    assign bus.round_o   = r_q;
    assign bus.sticky_o  = st_q;
    assign bus.inexact_o = inx_q;
endmodule

// File: tb/tb_iob_shift_round_seq.sv
// Directed scoreboard bench for iob_shift_round_seq (DATA_W=32, STEP=4).
module tb_iob_shift_round_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    iob_shift_round_seq_if #(.DATA_W(32), .SHIFT_W(16)) ifc ();

    iob_shift_round_seq #(.DATA_W(32), .SHIFT_W(16), .STEP(4)) dut (
        .clk_i    (clk),
        .arst_n_i (rst_n),
        .bus      (ifc.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] man;
        logic        g;
        logic        r;
        logic        s;
        int          exp_edge;
    } exp_t;

    exp_t sb[$];
    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done_o pulse is matched against the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (ifc.done_o === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done_o=1 expected no result pending (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_edge", 64'(edge_cnt), 64'(e.exp_edge));
                check("man_o", 64'(ifc.man_o), 64'(e.man));
                check("guard_o", 64'(ifc.guard_o), 64'(e.g));
                check("round_o", 64'(ifc.round_o), 64'(e.r));
                check("sticky_o", 64'(ifc.sticky_o), 64'(e.s));
                check("inexact_o", 64'(ifc.inexact_o), 64'(e.g | e.r | e.s));
                check("ready_at_done", 64'(ifc.ready_o), 64'(1));
            end
        end
    end

    // Issue one request; n is the hand-computed number of SHIFT cycles.
    task automatic issue(input logic [31:0] m, input logic [15:0] sh,
                         input logic [31:0] em, input logic eg, input logic er,
                         input logic es, input int n);
        int   waited;
        exp_t e;
        waited = 0;
        @(negedge clk);
        while (ifc.ready_o !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (ifc.ready_o !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got ready_o=%b expected 1 within 200 cycles", ifc.ready_o);
            return;
        end
        ifc.start_i = 1'b1;
        ifc.man_i   = m;
        ifc.shift_i = sh;
        @(posedge clk);
        #1;
        ifc.start_i = 1'b0;
        ifc.man_i   = $urandom;
        ifc.shift_i = 16'($urandom);
        e.man = em; e.g = eg; e.r = er; e.s = es;
        e.exp_edge = edge_cnt + n + 1;
        sb.push_back(e);
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (sb.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("drain_pending", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        ifc.start_i = 1'b0;
        ifc.man_i   = '0;
        ifc.shift_i = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(ifc.ready_o), 64'(1));
        check("rst_done", 64'(ifc.done_o), 64'(0));
        check("rst_man", 64'(ifc.man_o), 64'(0));
        check("rst_flags", 64'({ifc.guard_o, ifc.round_o, ifc.sticky_o, ifc.inexact_o}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back directed vectors.
        issue(32'ha2e513cd, 16'd5,  32'h0517289E, 1'b0, 1'b1, 1'b1, 2);
        issue(32'ha2e51300, 16'd5,  32'h05172898, 1'b0, 1'b0, 1'b0, 2);
        issue(32'ha2e513cd, 16'd30, 32'h00000003, 1'b1, 1'b0, 1'b1, 8);
        issue(32'ha2e513cd, 16'd1,  32'h517289E6, 1'b1, 1'b0, 1'b0, 1);
        issue(32'hFFFFFFFF, 16'd1,  32'h80000000, 1'b1, 1'b0, 1'b0, 1);
        issue(32'ha2e513cd, 16'd40, 32'h00000000, 1'b0, 1'b0, 1'b1, 9);
        issue(32'ha2e513cd, 16'd0,  32'ha2e513cd, 1'b0, 1'b0, 1'b0, 0);
        issue(32'h00000000, 16'd17, 32'h00000000, 1'b0, 1'b0, 1'b0, 5);
        issue(32'h80000000, 16'd34, 32'h00000000, 1'b0, 1'b0, 1'b1, 9);
        issue(32'h80000000, 16'd33, 32'h00000000, 1'b0, 1'b1, 1'b0, 9);
        issue(32'h80000000, 16'd32, 32'h00000000, 1'b1, 1'b0, 1'b0, 8);
        issue(32'h00000003, 16'd2,  32'h00000001, 1'b1, 1'b1, 1'b0, 1);
        issue(32'hFFFFFFFF, 16'hFFFF, 32'h00000000, 1'b0, 1'b0, 1'b1, 9);
        drain();

        // start while busy must be ignored.
        issue(32'ha2e513cd, 16'd30, 32'h00000003, 1'b1, 1'b0, 1'b1, 8);
        repeat (2) @(negedge clk);
        check("busy_ready", 64'(ifc.ready_o), 64'(0));
        ifc.start_i = 1'b1;
        ifc.man_i   = 32'hFFFFFFFF;
        ifc.shift_i = 16'd0;
        @(negedge clk);
        ifc.start_i = 1'b0;
        drain();

        // Reset in the middle of SHIFT discards the operation.
        issue(32'ha2e513cd, 16'd30, 32'h00000003, 1'b1, 1'b0, 1'b1, 8);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("midrst_ready", 64'(ifc.ready_o), 64'(1));
        check("midrst_done", 64'(ifc.done_o), 64'(0));
        check("midrst_man", 64'(ifc.man_o), 64'(0));
        check("midrst_flags", 64'({ifc.guard_o, ifc.round_o, ifc.sticky_o, ifc.inexact_o}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        issue(32'ha2e513cd, 16'd5, 32'h0517289E, 1'b0, 1'b1, 1'b1, 2);
        drain();

        // Results hold while idle.
        repeat (5) @(negedge clk);
        check("hold_man", 64'(ifc.man_o), 64'(32'h0517289E));
        check("hold_flags", 64'({ifc.guard_o, ifc.round_o, ifc.sticky_o, ifc.inexact_o}), 64'(4'b0111));
        check("hold_done", 64'(ifc.done_o), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
